// File: rtl/period_qualifier.sv
// period_qualifier: synchronises and glitch-filters comp_in, measures its period and flags lock.
// Define PERIOD_QUAL_DUTY_EN to add the high_time output and duty-cycle matching.
module period_qualifier #(
  parameter int unsigned CNT_WIDTH     = 20,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned TOL           = 8,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned TIMEOUT       = (1 << 20) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 comp_in,
  output logic                 signal_out,
  output logic                 edge_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 stable
`ifdef PERIOD_QUAL_DUTY_EN
  ,
  output logic [CNT_WIDTH-1:0] high_time
`endif
);

  localparam int unsigned RUN_W   = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] TOL_C      = CNT_WIDTH'(TOL);
  localparam logic [RUN_W-1:0]     RUN_LAST   = RUN_W'(GLITCH_CYCLES - 1);
  localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MATCH_W-1:0]   MATCH_FULL = MATCH_W'(LOCK_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEEK = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [RUN_W-1:0]       r_run;
  logic                   r_level;
  logic                   r_edge;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_prev;
  logic [CNT_WIDTH-1:0]   r_period;
  logic                   r_pv;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [MATCH_W-1:0]     r_match;
  logic [MATCH_W-1:0]     w_match_nxt;
  logic                   r_prev_ok;
  logic                   w_prev_ok_nxt;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   w_sample;
  logic                   w_timeout;
  logic                   w_take;
  logic                   w_match;
  logic                   w_duty_ok;

  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
  end

  // Run of samples disagreeing with the filtered level; a full run flips the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= '0;
      r_level <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      if (w_sample == r_level) begin
        r_run <= '0;
      end else if (r_run == RUN_LAST) begin
        r_run   <= '0;
        r_level <= w_sample;
        r_edge  <= w_sample;
      end else begin
        r_run <= r_run + RUN_W'(1);
      end
    end
  end

  // Period counter: restarts at 1 on each qualified edge, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable || (r_state == S_IDLE)) begin
      r_cnt <= '0;
    end else if (r_edge) begin
      r_cnt <= CNT_WIDTH'(1);
    end else if (r_cnt != TIMEOUT_C) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_timeout = (r_cnt == TIMEOUT_C);
  assign w_take    = enable && r_edge && !w_timeout &&
                     ((r_state == S_MEAS) || (r_state == S_LOCK));
  assign w_match   = r_prev_ok && (abs_diff(r_cnt, r_prev) <= TOL_C) && w_duty_ok;

`ifdef PERIOD_QUAL_DUTY_EN
  logic [CNT_WIDTH-1:0] r_hcnt;
  logic [CNT_WIDTH-1:0] r_high_time;
  logic [CNT_WIDTH-1:0] r_prev_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
    end else if (!enable || (r_state == S_IDLE)) begin
      r_hcnt <= '0;
    end else if (r_edge) begin
      r_hcnt <= CNT_WIDTH'(1);
    end else if (r_level && (r_hcnt != TIMEOUT_C)) begin
      r_hcnt <= r_hcnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_time <= '0;
      r_prev_hi   <= '0;
    end else if (w_take) begin
      r_high_time <= r_hcnt;
      r_prev_hi   <= r_hcnt;
    end
  end

  assign w_duty_ok = (abs_diff(r_hcnt, r_prev_hi) <= TOL_C);
  assign high_time = r_high_time;
`else
  assign w_duty_ok = 1'b1;
`endif

  // Measurement capture: period and previous-period reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
      r_prev   <= '0;
      r_pv     <= 1'b0;
    end else begin
      r_pv <= w_take;
      if (w_take) begin
        r_period <= r_cnt;
        r_prev   <= r_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_match   <= '0;
      r_prev_ok <= 1'b0;
      r_stable  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
      r_prev_ok <= w_prev_ok_nxt;
      r_stable  <= w_stable_nxt;
    end
  end

  // Lock FSM: enable loss beats timeout, timeout beats a coincident edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_match_nxt   = r_match;
    w_prev_ok_nxt = r_prev_ok;
    w_stable_nxt  = r_stable;
    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_match_nxt   = '0;
      w_prev_ok_nxt = 1'b0;
      w_stable_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_SEEK;
        S_SEEK: begin
          if (r_edge) begin
            w_state_nxt   = S_MEAS;
            w_prev_ok_nxt = 1'b0;
          end
        end
        S_MEAS, S_LOCK: begin
          if (w_timeout) begin
            w_state_nxt   = S_SEEK;
            w_match_nxt   = '0;
            w_prev_ok_nxt = 1'b0;
            w_stable_nxt  = 1'b0;
          end else if (r_edge) begin
            w_prev_ok_nxt = 1'b1;
            if (!w_match) begin
              w_state_nxt  = S_MEAS;
              w_match_nxt  = '0;
              w_stable_nxt = 1'b0;
            end else if (r_state == S_MEAS) begin
              if (r_match == MATCH_LAST) begin
                w_state_nxt  = S_LOCK;
                w_match_nxt  = MATCH_FULL;
                w_stable_nxt = 1'b1;
              end else begin
                w_match_nxt = r_match + MATCH_W'(1);
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign signal_out   = r_level;
  assign edge_pulse   = r_edge;
  assign period       = r_period;
  assign period_valid = r_pv;
  assign stable       = r_stable;

endmodule

// File: doc/period_qualifier.md
# period_qualifier

Front-end conditioning stage for the capture path. It takes the raw comparator square wave, which is asynchronous, and synchronises and glitch-filters it. It measures the signal period in `clk` cycles and asserts `stable` once the period has held steady. Its `signal_out` and `stable` feed the ping-pong capture buffer's `signal_in`/`stable` inputs, so capture starts only on a locked, clean trigger.

## Interface
Parameters:
- `CNT_WIDTH`, 20: width of the period counter and of `period`.
- `SYNC_STAGES`, 2: number of synchroniser flops on `comp_in`; must be ≥2.
- `GLITCH_CYCLES`, 4: consecutive equal samples required before `signal_out` changes.
- `TOL`, 8: maximum |period − previous period|, in cycles, that still counts as a match.
- `LOCK_COUNT`, 4: number of consecutive matches required to assert `stable`.
- `TIMEOUT`, 2^20−1: number of cycles without a qualified rising edge before the block declares loss of signal; must be ≤ 2^CNT_WIDTH−1.

Ports:
- `clk` in 1: system clock; all logic is in this domain. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: synchronous qualify-enable.
- `comp_in` in 1: comparator output; asynchronous to `clk`.
- `signal_out` out 1: synchronised, glitch-filtered level.
- `edge_pulse` out 1: one-cycle pulse on each qualified rising edge.
- `period` out CNT_WIDTH: last measured period, in `clk` cycles.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `stable` out 1: the period is locked.

## Operation
- **Reset.** Every flop clears asynchronously, including the synchroniser, filter, counters and FSM. All outputs are 0. The FSM state is IDLE.
- **Filter.**
  - A saturating run counter counts samples of the synchroniser output that differ from `signal_out`.
  - `signal_out` toggles when the run reaches `GLITCH_CYCLES`.
  - Any sample equal to `signal_out` clears the run.
  - `edge_pulse` is registered and is high in the cycle in which `signal_out` first reads 1.
  - The synchroniser and filter run regardless of `enable`.
- **Period counter.** The counter clears to 1 on `edge_pulse` and otherwise increments. It saturates at `TIMEOUT`. The value captured on an `edge_pulse` equals the number of cycles since the previous pulse.
- **FSM.**
  - IDLE: entered whenever `enable`=0. Counters are cleared. Go to SEEK when `enable`=1.
  - SEEK: waits for the first `edge_pulse`, then goes to MEASURE. No period is reported yet.
  - MEASURE, on each `edge_pulse`:
    - `period` takes the new count and `period_valid` pulses.
    - If |new − prev| ≤ `TOL`, `match_cnt` increments; otherwise it clears. The first measured period after SEEK always counts as a mismatch.
    - When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED and set `stable`=1.
  - LOCKED, on each `edge_pulse`:
    - A matching period keeps the lock.
    - A mismatch clears `stable` and `match_cnt` and goes to MEASURE. The new period becomes `prev`.
  - Timeout: in MEASURE or LOCKED, if the counter reaches `TIMEOUT`, clear `stable` and `match_cnt` and go to SEEK. `period` holds its value; no `period_valid` pulse.
- **Difference.** Computed as an unsigned difference of the larger minus the smaller, CNT_WIDTH bits wide; no overflow is possible.
- **Simultaneous events.**
  - `enable` falling wins over `edge_pulse` and over timeout.
  - An `edge_pulse` in the same cycle the counter hits `TIMEOUT` is treated as the timeout.
- **Reset mid-operation.** Outputs drop immediately. Lock is re-acquired from scratch after release.

## Timing
- Filter latency: a `comp_in` level change that is sampled at edge 0 and then held appears on `signal_out` after edge `SYNC_STAGES`+`GLITCH_CYCLES`−1 (edge 5 with defaults). `edge_pulse` asserts on that same edge.
- A pulse on `comp_in` shorter than `GLITCH_CYCLES` cycles produces no change on `signal_out`.
- `period`, `period_valid` and `stable` update on the clock edge after `edge_pulse`, i.e. with one cycle of latency.
- With defaults, `stable` rises one cycle after the 6th qualified rising edge: 1 edge for SEEK, 1 for the first (unmatched) period, then 4 matches.
- Loss of lock from a mismatch or from `enable`=0 takes effect one cycle after the cause.
- Loss of lock from a timeout takes effect on the edge after the counter reaches `TIMEOUT`.

## Configuration
- Macro `PERIOD_QUAL_DUTY_EN`.
- Defined:
  - Adds output port `high_time` [CNT_WIDTH−1:0]: the number of cycles `signal_out` was high in the last period, updated together with `period`.
  - A match additionally requires |high_time − prev_high_time| ≤ `TOL`.
- Undefined: the port and its logic are absent; matching uses the period only.

## Test plan
- **Reset:** assert `rst` for 3 cycles while `comp_in` toggles → all outputs read 0 during and immediately after reset.
- **Clean lock:** `TIMEOUT`=1000, `enable`=1, `comp_in` is a 200-cycle square wave at 50% duty → `period`=200 on every `period_valid`; `stable`=1 one cycle after the 6th `edge_pulse`. With `PERIOD_QUAL_DUTY_EN` defined, `high_time`=100.
- **Glitch:** apply a 3-cycle high pulse on a low `comp_in` → `signal_out` and `edge_pulse` stay 0, and `period` is unchanged. A 4-cycle pulse → one `edge_pulse`, 5 cycles after the pulse's first sampling edge.
- **Drift and jump while locked:** periods 200→205 → `stable` stays 1. Then 205→220 → `stable` goes to 0 one cycle after the edge that ends the 220 period. Four further 220 periods → `stable` returns to 1.
- **Loss of signal:** while locked, hold `comp_in` low → `stable`=0 exactly `TIMEOUT` (1000) cycles after the last `edge_pulse`, with no `period_valid`. Restart the wave → relocks after 6 edges.
- **Enable/reset mid-lock:** drop `enable` for 1 cycle → `stable`=0 on the next cycle, and relock takes 6 edges. Assert `rst` mid-period → outputs 0 asynchronously, before the next `clk` edge.
